// File: rtl/adder_cpu_ctrl_if.sv
// adder_cpu_ctrl_if: memory request/acknowledge handshake between the control unit and shared memory
// mem_rd, mem_wr : read/write request, held until mem_ack
// addr_sel       : 0 selects PC, 1 selects IR[5:0] as memory address
// mem_ack        : memory completes the current request this cycle
interface adder_cpu_ctrl_if;
    logic mem_rd;
    logic mem_wr;
    logic addr_sel;
    logic mem_ack;
    modport master (output mem_rd, output mem_wr, output addr_sel, input mem_ack);
    modport slave (input mem_rd, input mem_wr, input addr_sel, output mem_ack);
endinterface

// File: rtl/adder_cpu_ctrl.sv
// adder_cpu_ctrl: multi-cycle fetch/decode/execute sequencer for the adding-machine CPU
// clk, rst_n          : clock, asynchronous active-low reset
// start, stop, step   : run control (step only acts when STEP_EN is defined)
// opcode              : IR[7:6], 00 LDA, 01 ADD, 10 STA, 11 JMP
// mem                 : memory handshake (adder_cpu_ctrl_if.master)
// clr_pc/ld_pc/inc_pc : program counter strobes
// clr_ac/ld_ac/alu_add: accumulator strobes, alu_add selects AC+data over data
// ld_ir               : instruction register load
// busy, icnt          : not-IDLE flag, retired-instruction count (wraps)
// Macro STEP_EN adds a PAUSE state between instructions released by step.
module adder_cpu_ctrl #(
    parameter int ICNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic [1:0]        opcode,
    adder_cpu_ctrl_if.master  mem,
    output logic              clr_pc,
    output logic              ld_pc,
    output logic              inc_pc,
    output logic              clr_ac,
    output logic              ld_ac,
    output logic              alu_add,
    output logic              ld_ir,
    output logic              busy,
    output logic [ICNT_W-1:0] icnt
);
    typedef enum logic [3:0] {
        IDLE, INIT, FETCH, LOAD_IR, DECODE, RD, EXEC, WR, JUMP, DONE
`ifdef STEP_EN
        , PAUSE
`endif
    } state_t;
    state_t state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic unused_step;
    assign unused_step = step;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        case (state_q)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT: begin
                state_d = FETCH;
                icnt_d  = '0;
            end
            FETCH:   state_d = mem.mem_ack ? LOAD_IR : FETCH;
            LOAD_IR: state_d = DECODE;
            DECODE:  state_d = opcode == 2'b10 ? WR : opcode == 2'b11 ? JUMP : RD;
            RD:      state_d = mem.mem_ack ? EXEC : RD;
            EXEC:    state_d = DONE;
            WR:      state_d = mem.mem_ack ? DONE : WR;
            JUMP:    state_d = DONE;
            DONE: begin
                icnt_d = icnt_q + 1'b1;
`ifdef STEP_EN
                state_d = stop ? IDLE : PAUSE;
`else
                state_d = stop ? IDLE : FETCH;
`endif
            end
`ifdef STEP_EN
            PAUSE:   state_d = stop ? IDLE : step ? FETCH : PAUSE;
`endif
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        clr_pc       = state_q == INIT;
        clr_ac       = state_q == INIT;
        ld_ir        = state_q == LOAD_IR;
        inc_pc       = state_q == LOAD_IR;
        ld_pc        = state_q == JUMP;
        ld_ac        = state_q == EXEC;
        alu_add      = state_q == EXEC && opcode == 2'b01;
        mem.mem_rd   = state_q == FETCH || state_q == RD;
        mem.mem_wr   = state_q == WR;
        mem.addr_sel = state_q == RD || state_q == WR;
        busy         = state_q != IDLE;
    end
    assign icnt = icnt_q;
endmodule

// File: tb/tb_adder_cpu_ctrl.sv
// tb_adder_cpu_ctrl: directed bench with memory/datapath model and write scoreboard
module tb_adder_cpu_ctrl;
    localparam int ICNT_W = 8;
`ifdef STEP_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif
    logic clk = 0, rst_n = 1, start = 0, stop = 0, step = 0;
    logic [1:0] opcode;
    logic clr_pc, ld_pc, inc_pc, clr_ac, ld_ac, alu_add, ld_ir, busy;
    logic [ICNT_W-1:0] icnt;
    logic [7:0] mem [64];
    logic [7:0] ir, ac, rdata;
    logic [5:0] pc, addr;
    int ack_delay = 0, wcnt = 0, n_wr = 0, viol = 0;
    int errors = 0, checks = 0;
    logic [13:0] exp_q[$], obs_q[$];

    adder_cpu_ctrl_if bus();

    adder_cpu_ctrl #(.ICNT_W(ICNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
        .opcode(opcode), .mem(bus),
        .clr_pc(clr_pc), .ld_pc(ld_pc), .inc_pc(inc_pc), .clr_ac(clr_ac),
        .ld_ac(ld_ac), .alu_add(alu_add), .ld_ir(ld_ir), .busy(busy), .icnt(icnt)
    );

    always #5 clk = ~clk;

    assign opcode = ir[7:6];
    assign addr = bus.addr_sel ? ir[5:0] : pc;
    assign bus.mem_ack = (bus.mem_rd || bus.mem_wr) && wcnt >= ack_delay;

    always @(posedge clk) begin
        wcnt <= (bus.mem_rd || bus.mem_wr) && !bus.mem_ack ? wcnt + 1 : 0;
        if (bus.mem_rd && bus.mem_ack) rdata <= mem[addr];
        if (bus.mem_wr && bus.mem_ack) begin
            mem[addr] <= ac;
            n_wr <= n_wr + 1;
            obs_q.push_back({addr, ac});
        end
        pc <= clr_pc ? 6'd0 : ld_pc ? ir[5:0] : inc_pc ? pc + 6'd1 : pc;
        ir <= ld_ir ? rdata : ir;
        ac <= clr_ac ? 8'd0 : ld_ac ? (alu_add ? ac + rdata : rdata) : ac;
    end

    always @(negedge clk)
        if (32'(clr_pc) + 32'(ld_pc) + 32'(inc_pc) > 1 || (bus.mem_rd && bus.mem_wr)) viol <= viol + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_writes();
        chk("wr_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) chk("wr_data", obs_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 8'h00;
        mem[0] = 8'h10;
        mem[1] = 8'h51;
        mem[2] = 8'h92;
        mem[3] = 8'hE0;
        mem[6'h10] = 8'd5;
        mem[6'h11] = 8'd7;
        mem[6'h20] = 8'hE0;
        #1 rst_n = 0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {clr_pc, ld_pc, inc_pc, clr_ac, ld_ac, alu_add, ld_ir, bus.mem_rd, bus.mem_wr}, 0);
        chk("rst_icnt", icnt, 0);
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        step = PX[0];
        // program run: LDA 0x10, ADD 0x11, STA 0x12, stop
        exp_q.push_back({6'h12, 8'd12});
        start = 1;
        @(negedge clk) start = 0;
        chk("init_clr", {clr_pc, clr_ac, busy}, 3'b111);
        @(negedge clk);
        chk("fetch_rd", {bus.mem_rd, bus.addr_sel, addr}, {1'b1, 1'b0, 6'h00});
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (bus.mem_wr) stop = 1;
            @(negedge clk);
        end
        stop = 0;
        chk("prog_cycles", n, 17 + 2 * PX);
        chk("prog_icnt", icnt, 3);
        chk("prog_ac", ac, 12);
        chk("prog_nwr", n_wr, 1);
        // rerun through JMP 0x20 at address 3, then loop on JMP 0x20
        exp_q.push_back({6'h12, 8'd12});
        start = 1;
        @(negedge clk) start = 0;
        for (n = 0; n < 100 && !ld_pc; n++) @(negedge clk);
        chk("jmp_seen", ld_pc, 1);
        chk("jmp_excl", {inc_pc, clr_pc}, 0);
        chk("jmp_ir", ir, 8'hE0);
        @(negedge clk);
        chk("jmp_pulse", ld_pc, 0);
        chk("jmp_pc", pc, 6'h20);
        for (n = 0; n < 10 && !bus.mem_rd; n++) @(negedge clk);
        chk("jmp_fetch", {bus.mem_rd, bus.addr_sel, addr}, {1'b1, 1'b0, 6'h20});
        chk("jmp_icnt", icnt, 4);
        for (n = 0; n < 3000 && icnt != 8'd255; n++) @(negedge clk);
        chk("icnt_255", icnt, 255);
        for (n = 0; n < 20 && icnt == 8'd255; n++) @(negedge clk);
        chk("icnt_wrap", icnt, 0);
        // fetch with three wait cycles
        for (n = 0; n < 20 && !ld_pc; n++) @(negedge clk);
        ack_delay = 3;
        for (n = 0; n < 10 && !bus.mem_rd; n++) @(negedge clk);
        n = 0;
        while (bus.mem_rd && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("wait_rd_len", n, 4);
        chk("wait_ldir", {ld_ir, inc_pc}, 2'b11);
        @(negedge clk);
        chk("wait_ldir_pulse", {ld_ir, inc_pc}, 2'b00);
        ack_delay = 0;
        stop = 1;
        for (n = 0; n < 20 && busy; n++) @(negedge clk);
        chk("loop_stop", busy, 0);
        stop = 0;
        // stop raised in RD; start+stop together in DONE
        ack_delay = 2;
        start = 1;
        @(negedge clk) start = 0;
        for (n = 0; n < 50 && !(bus.mem_rd && bus.addr_sel); n++) @(negedge clk);
        chk("rd_seen", {bus.mem_rd, bus.addr_sel}, 2'b11);
        stop = 1;
        for (n = 0; n < 20 && !ld_ac; n++) @(negedge clk);
        chk("rd_stop_exec", {ld_ac, busy}, 2'b11);
        @(negedge clk);
        chk("done_icnt", icnt, 0);
        start = 1;
        @(negedge clk) start = 0;
        chk("stop_idle", busy, 0);
        chk("stop_icnt", icnt, 1);
        chk("stop_ac", ac, 5);
        stop = 0;
        repeat (5) @(negedge clk);
        chk("no_restart", {busy, clr_pc, bus.mem_rd}, 0);
        // reset in the RD cycle of ADD
        ack_delay = 3;
        start = 1;
        @(negedge clk) start = 0;
        for (n = 0; n < 100 && !(icnt == 8'd1 && bus.mem_rd && bus.addr_sel); n++) @(negedge clk);
        chk("rst_pre", {bus.mem_rd, busy, icnt}, {1'b1, 1'b1, 8'd1});
        #2 rst_n = 0;
        #1;
        chk("rst_async_rd", bus.mem_rd, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_icnt", icnt, 0);
        @(negedge clk) rst_n = 1;
        ack_delay = 0;
        @(negedge clk);
        chk("rst_idle", busy, 0);
`ifdef STEP_EN
        step = 0;
        start = 1;
        @(negedge clk) start = 0;
        for (n = 0; n < 50 && icnt != 8'd1; n++) @(negedge clk);
        repeat (10) begin
            chk("pause_hold", {busy, bus.mem_rd, ld_ir}, 3'b100);
            @(negedge clk);
        end
        step = 1;
        @(negedge clk) step = 0;
        chk("step_fetch", bus.mem_rd, 1);
        for (n = 0; n < 50 && icnt != 8'd2; n++) @(negedge clk);
        chk("pause_icnt", icnt, 2);
        stop = 1;
        step = 1;
        @(negedge clk);
        chk("pause_stop", busy, 0);
        stop = 0;
        step = 0;
`endif
        chk_writes();
        chk("exclusive", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
